// File: rtl/req_burst_ctrl_pkg.sv
// Shared definitions for the burst request controller: client FSM encoding
// and the post-burst cool-down length.
package req_burst_ctrl_pkg;

  localparam int NUM_CLIENTS = 4;
  localparam int SRC_W       = 2;

  // Cool-down holds req low long enough for the arbiter to release its grant.
  localparam int COOL_CYCLES = 2;
  localparam int COOL_W      = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_COOL = 2'b10
  } client_state_e;

endpackage

// File: rtl/req_burst_ctrl_client.sv
// Per-client burst sequencer: accepts a start, requests the arbiter for len
// beats, then cools down before accepting the next burst.
//
//   state | meaning
//   IDLE  | waiting for start with a nonzero length
//   REQ   | req high, cnt_q beats still owed, one beat per selected grant
//   COOL  | req low for COOL_CYCLES while the arbiter drops its grant
module req_burst_client
  import req_burst_ctrl_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          beat,
  output logic          req,
  output logic          done
);

  client_state_e state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              req_q, req_d;
  logic              done_q, done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cool_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cool_d  = cool_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d = ST_REQ;
          cnt_d   = len;
        end
      end
      ST_REQ: begin
        if (beat) begin
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = ST_COOL;
            cool_d  = COOL_W'(COOL_CYCLES - 1);
            done_d  = 1'b1;
          end
        end
      end
      ST_COOL: begin
        if (cool_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q - COOL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cool_d  = '0;
      end
    endcase
    req_d = (state_d == ST_REQ);
  end

  assign req  = req_q;
  assign done = done_q;

endmodule

// File: rtl/req_burst_ctrl.sv
// Four-client burst request controller: per-client sequencers, lowest-index
// beat selection among granted requesters, registered data mux and error flag.
module req_burst_ctrl
  import req_burst_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_0,
  input  logic             start_1,
  input  logic             start_2,
  input  logic             start_3,
  input  logic [LW-1:0]    len,
  input  logic [DW-1:0]    data_in_0,
  input  logic [DW-1:0]    data_in_1,
  input  logic [DW-1:0]    data_in_2,
  input  logic [DW-1:0]    data_in_3,
  input  logic             gnt_0,
  input  logic             gnt_1,
  input  logic             gnt_2,
  input  logic             gnt_3,
  output logic             req_0,
  output logic             req_1,
  output logic             req_2,
  output logic             req_3,
  output logic             done_0,
  output logic             done_1,
  output logic             done_2,
  output logic             done_3,
  output logic [DW-1:0]    data_out,
  output logic             data_valid,
  output logic [SRC_W-1:0] data_src,
  output logic             multi_gnt_err
);

  logic [NUM_CLIENTS-1:0] start_vec, gnt_vec, req_vec, done_vec, beat_vec;
  logic [DW-1:0]          din_vec [NUM_CLIENTS];
  logic [SRC_W-1:0]       sel_idx;
  logic                   any_beat;
  logic                   multi_gnt;

  logic [DW-1:0]    data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  assign start_vec  = {start_3, start_2, start_1, start_0};
  assign gnt_vec    = {gnt_3, gnt_2, gnt_1, gnt_0};
  assign din_vec[0] = data_in_0;
  assign din_vec[1] = data_in_1;
  assign din_vec[2] = data_in_2;
  assign din_vec[3] = data_in_3;

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_client
    req_burst_client #(
      .LW(LW)
    ) u_client (
      .clock (clock),
      .reset (reset),
      .start (start_vec[k]),
      .len   (len),
      .beat  (beat_vec[k]),
      .req   (req_vec[k]),
      .done  (done_vec[k])
    );
  end

  // A grant only counts for a client that is currently requesting; among
  // several such clients the lowest index wins the beat.
  always_comb begin
    beat_vec = '0;
    sel_idx  = '0;
    any_beat = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!any_beat && gnt_vec[i] && req_vec[i]) begin
        beat_vec[i] = 1'b1;
        sel_idx     = SRC_W'(i);
        any_beat    = 1'b1;
      end
    end
  end

  assign multi_gnt = ($countones(gnt_vec) > 1);

  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = any_beat;
    err_d   = err_q | multi_gnt;
    if (any_beat) begin
      data_d = din_vec[sel_idx];
      src_d  = sel_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign req_0         = req_vec[0];
  assign req_1         = req_vec[1];
  assign req_2         = req_vec[2];
  assign req_3         = req_vec[3];
  assign done_0        = done_vec[0];
  assign done_1        = done_vec[1];
  assign done_2        = done_vec[2];
  assign done_3        = done_vec[3];
  assign data_out      = data_q;
  assign data_src      = src_q;
  assign data_valid    = valid_q;
  assign multi_gnt_err = err_q;

endmodule

// File: tb/tb_req_burst_ctrl.sv
// Scoreboard bench for req_burst_ctrl: a beat-level reference model queues
// expected words, a negedge monitor pops and compares whatever the DUT emits.
module tb_req_burst_ctrl;

  localparam int DW = 8;
  localparam int LW = 4;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    start_v, gnt_v;
  logic [LW-1:0] len;
  logic [DW-1:0] din [4];

  logic          req_0, req_1, req_2, req_3;
  logic          done_0, done_1, done_2, done_3;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [1:0]    data_src;
  logic          multi_gnt_err;
  logic [3:0]    req_dut, done_dut;

  assign req_dut  = {req_3, req_2, req_1, req_0};
  assign done_dut = {done_3, done_2, done_1, done_0};

  req_burst_ctrl #(.DW(DW), .LW(LW)) dut (
    .clock(clock), .reset(reset),
    .start_0(start_v[0]), .start_1(start_v[1]), .start_2(start_v[2]), .start_3(start_v[3]),
    .len(len),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .gnt_0(gnt_v[0]), .gnt_1(gnt_v[1]), .gnt_2(gnt_v[2]), .gnt_3(gnt_v[3]),
    .req_0(req_0), .req_1(req_1), .req_2(req_2), .req_3(req_3),
    .done_0(done_0), .done_1(done_1), .done_2(done_2), .done_3(done_3),
    .data_out(data_out), .data_valid(data_valid), .data_src(data_src),
    .multi_gnt_err(multi_gnt_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: beats still owed and cool-down cycles left per client.
  int         rem [4];
  int         cool [4];
  logic [3:0] exp_req, exp_done;
  logic       exp_valid, exp_err;
  beat_t      sb_q [$];
  beat_t      last_beat;
  beat_t      item;
  int         beats_seen [4];
  int         dones_seen [4];
  int         src_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      rem[k]  = 0;
      cool[k] = 0;
    end
    exp_req   = '0;
    exp_done  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    sb_q.delete();
    last_beat = '0;
  endfunction

  // Effect of the coming rising edge given the inputs now on the pins.
  function automatic void model_edge();
    int win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && gnt_v[k] && rem[k] > 0) win = k;
    if ($countones(gnt_v) > 1) exp_err = 1'b1;
    exp_done  = '0;
    exp_valid = (win >= 0);
    for (int k = 0; k < 4; k++) begin
      if (rem[k] > 0) begin
        if (win == k) begin
          sb_q.push_back(beat_t'{src: 2'(k), data: din[k]});
          rem[k] = rem[k] - 1;
          if (rem[k] == 0) begin
            cool[k]     = 2;
            exp_done[k] = 1'b1;
          end
        end
      end else if (cool[k] > 0) begin
        cool[k] = cool[k] - 1;
      end else if (start_v[k] && len != 0) begin
        rem[k] = int'(len);
      end
    end
    for (int k = 0; k < 4; k++) exp_req[k] = (rem[k] > 0);
  endfunction

  task automatic drive(input logic [3:0] st, input logic [LW-1:0] l, input logic [3:0] g);
    start_v = st;
    len     = l;
    gnt_v   = g;
    for (int k = 0; k < 4; k++)
      if (!exp_req[k]) din[k] = DW'($urandom);
    model_edge();
  endtask

  task automatic step(input logic [3:0] st, input logic [LW-1:0] l, input logic [3:0] g);
    @(negedge clock);
    #1;
    drive(st, l, g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, '0, 4'b0000);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"},   32'(req_dut), 32'd0);
    chk({tag, "_done"},  32'(done_dut), 32'd0);
    chk({tag, "_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_err"},   32'(multi_gnt_err), 32'd0);
    chk({tag, "_data"},  32'(data_out), 32'd0);
    chk({tag, "_src"},   32'(data_src), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("req", 32'(req_dut), 32'(exp_req));
      chk("done", 32'(done_dut), 32'(exp_done));
      chk("valid", 32'(data_valid), 32'(exp_valid));
      chk("err", 32'(multi_gnt_err), 32'(exp_err));
      for (int k = 0; k < 4; k++) if (done_dut[k]) dones_seen[k]++;
      if (data_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 32'(data_valid), 32'd0);
        end else begin
          item = sb_q.pop_front();
          chk("data", 32'(data_out), 32'(item.data));
          chk("src", 32'(data_src), 32'(item.src));
          last_beat = item;
        end
        beats_seen[data_src]++;
        src_log.push_back(int'(data_src));
      end else begin
        chk("hold_data", 32'(data_out), 32'(last_beat.data));
        chk("hold_src", 32'(data_src), 32'(last_beat.src));
      end
    end
  end

  int b0 [4];
  int d0 [4];

  task automatic snap();
    for (int k = 0; k < 4; k++) begin
      b0[k] = beats_seen[k];
      d0[k] = dones_seen[k];
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      beats_seen[k] = 0;
      dones_seen[k] = 0;
      din[k] = '0;
    end
    model_clear();
    start_v = '0;
    gnt_v   = '0;
    len     = '0;
    reset   = 1'b1;
    #1;
    chk_zero_outputs("por");
    @(negedge clock);
    #1;
    reset = 1'b0;
    drive(4'b0000, '0, 4'b0000);
    idle(2);

    // Client 2, len 3, grant held from two cycles after req rises through cool-down.
    snap();
    step(4'b0100, LW'(3), 4'b0000);
    step(4'b0000, '0, 4'b0000);
    for (int i = 0; i < 7; i++) step(4'b0000, '0, 4'b0100);
    idle(3);
    chk("c2_beats", 32'(beats_seen[2] - b0[2]), 32'd3);
    chk("c2_done", 32'(dones_seen[2] - d0[2]), 32'd1);

    // Client 0, len 2, grant toggling with a gap.
    snap();
    step(4'b0001, LW'(2), 4'b0000);
    step(4'b0000, '0, 4'b0001);
    step(4'b0000, '0, 4'b0000);
    step(4'b0000, '0, 4'b0001);
    idle(4);
    chk("c0_beats", 32'(beats_seen[0] - b0[0]), 32'd2);
    chk("c0_done", 32'(dones_seen[0] - d0[0]), 32'd1);

    // Zero-length start is ignored.
    snap();
    step(4'b0010, '0, 4'b0000);
    idle(3);
    chk("len0_req1", 32'(req_1), 32'd0);
    chk("len0_done", 32'(dones_seen[1] - d0[1]), 32'd0);

    // Simultaneous grants: lowest requesting index wins, error is sticky.
    snap();
    step(4'b1010, LW'(2), 4'b0000);
    step(4'b0000, '0, 4'b1010);
    step(4'b0000, '0, 4'b1010);
    idle(1);
    chk("mg_c1_beats", 32'(beats_seen[1] - b0[1]), 32'd2);
    chk("mg_c3_beats", 32'(beats_seen[3] - b0[3]), 32'd0);
    chk("mg_err", 32'(multi_gnt_err), 32'd1);
    idle(4);
    chk("mg_err_sticky", 32'(multi_gnt_err), 32'd1);
    step(4'b0000, '0, 4'b1000);
    step(4'b0000, '0, 4'b1000);
    idle(4);

    // Asynchronous reset mid-burst after one of four beats.
    step(4'b0010, LW'(4), 4'b0000);
    step(4'b0000, '0, 4'b0010);
    @(posedge clock);
    #2;
    chk("pre_rst_valid", 32'(data_valid), 32'd1);
    snap();
    #1;
    reset = 1'b1;
    #1;
    chk_zero_outputs("mid_rst");
    model_clear();
    start_v = '0;
    gnt_v   = '0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    drive(4'b0010, LW'(4), 4'b0000);
    for (int i = 0; i < 4; i++) step(4'b0000, '0, 4'b0010);
    idle(4);
    chk("rst_c1_beats", 32'(beats_seen[1] - b0[1]), 32'd4);
    chk("rst_c1_done", 32'(dones_seen[1] - d0[1]), 32'd1);

    // With a fixed-priority arbiter driven from req: all four clients, len 2.
    snap();
    src_log.delete();
    step(4'b1111, LW'(2), 4'b0000);
    for (int i = 0; i < 14; i++) begin
      logic [3:0] g;
      @(negedge clock);
      #1;
      g = '0;
      for (int k = 3; k >= 0; k--) if (req_dut[k]) g = 4'(1 << k);
      drive(4'b0000, '0, g);
    end
    idle(2);
    chk("arb_total", 32'(src_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < src_log.size()) chk("arb_order", 32'(src_log[i]), 32'(i / 2));
    end
    for (int k = 0; k < 4; k++)
      chk("arb_done", 32'(dones_seen[k] - d0[k]), 32'd1);

    // Randomized traffic, including starts during active bursts and multi grants.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] st, g;
      st = '0;
      for (int k = 0; k < 4; k++) st[k] = ($urandom_range(0, 5) == 0);
      g = 4'($urandom);
      if ($urandom_range(0, 3) == 0) g = '0;
      step(st, LW'($urandom_range(0, 15)), g);
    end
    for (int i = 0; i < 80; i++) begin
      logic [3:0] g;
      @(negedge clock);
      #1;
      g = '0;
      for (int k = 3; k >= 0; k--) if (req_dut[k]) g = 4'(1 << k);
      drive(4'b0000, '0, g);
    end
    idle(4);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
